mix_columns_iter: RTL and testbench

- AES MixColumns round stage. It sits directly downstream of shift_rows and consumes its 128-bit output.
- Accepts one 128-bit state through a valid/ready handshake and transforms COLS_PER_CYCLE columns per clock.
- Holds the result until the downstream AddRoundKey stage takes it.
- Provides backpressure so the iterative datapath can share the round loop.

---
 rtl/mix_columns_iter.sv | 195 +++++++++++++++++++
 tb/tb_mix_columns_iter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_iter.sv
// mix_columns_iter -- iterative AES MixColumns stage.
//
// Takes one 128-bit state from shift_rows over a valid/ready handshake,
// mixes COLS_PER_CYCLE columns per BUSY cycle (4/COLS_PER_CYCLE cycles per
// state) and holds the result on out until AddRoundKey takes it.
//
// Byte layout (in and out): column-major, byte 0 = [127:120],
// column c = [127-32c -: 32], top byte of a column = row 0.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in         state from shift_rows
//   in_valid   in holds a valid state
//   in_ready   block can accept a state this cycle (combinational)
//   inv        (MIX_COLUMNS_INV_EN only) 1 = InvMixColumns, latched at accept
//   out        mixed state, held until transferred
//   out_valid  out holds a completed state
//   out_ready  downstream accepts out this cycle
//
// Optional feature macro: MIX_COLUMNS_INV_EN adds the inv port and the
// InvMixColumns datapath. Without it the block is forward-only.

// One column through the (Inv)MixColumns matrix in GF(2^8), poly 0x11B.
module mix_columns_col (
   input  logic [31:0] col_i,
`ifdef MIX_COLUMNS_INV_EN
   input  logic        inv_i,
`endif
   output logic [31:0] col_o
);
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   logic [7:0] a  [4];
   logic [7:0] x2 [4];
   logic [7:0] x3 [4];
   logic [7:0] r  [4];

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         a[i]  = col_i[31-8*i -: 8];
         x2[i] = xt(a[i]);
         x3[i] = x2[i] ^ a[i];
      end
      r[0] = x2[0] ^ x3[1] ^ a[2]  ^ a[3];
      r[1] = a[0]  ^ x2[1] ^ x3[2] ^ a[3];
      r[2] = a[0]  ^ a[1]  ^ x2[2] ^ x3[3];
      r[3] = x3[0] ^ a[1]  ^ a[2]  ^ x2[3];
   end

`ifdef MIX_COLUMNS_INV_EN
   // Inverse coefficients from chained xtime: 9=8+1, b=8+2+1, d=8+4+1, e=8+4+2.
   logic [7:0] x4 [4];
   logic [7:0] x8 [4];
   logic [7:0] m9 [4];
   logic [7:0] mb [4];
   logic [7:0] md [4];
   logic [7:0] me [4];
   logic [7:0] ri [4];

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         x4[i] = xt(x2[i]);
         x8[i] = xt(x4[i]);
         m9[i] = x8[i] ^ a[i];
         mb[i] = x8[i] ^ x2[i] ^ a[i];
         md[i] = x8[i] ^ x4[i] ^ a[i];
         me[i] = x8[i] ^ x4[i] ^ x2[i];
      end
      ri[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      ri[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      ri[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      ri[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
   end

   assign col_o = inv_i ? {ri[0], ri[1], ri[2], ri[3]} : {r[0], r[1], r[2], r[3]};
`else
   assign col_o = {r[0], r[1], r[2], r[3]};
`endif
endmodule

module mix_columns_iter #(
   parameter int COLS_PER_CYCLE = 1   // 1, 2 or 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] in,
   input  logic         in_valid,
   output logic         in_ready,
`ifdef MIX_COLUMNS_INV_EN
   input  logic         inv,
`endif
   output logic [127:0] out,
   output logic         out_valid,
   input  logic         out_ready
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                             state_q;
   logic [1:0]                         col_q;
   logic [3:0][31:0]                   work_q, work_d;  // work_q[3] = column 0
   logic [127:0]                       out_q;
   logic                               out_valid_q;
   logic [COLS_PER_CYCLE-1:0][1:0]     lane_col;
   logic [COLS_PER_CYCLE-1:0][31:0]    lane_in, lane_out;
   logic                               last;
`ifdef MIX_COLUMNS_INV_EN
   logic                               inv_q;
`endif

   // Lane k works on column col_q+k; column c lives at work_q[3-c] = work_q[~c].
   always_comb begin
      for (int k = 0; k < COLS_PER_CYCLE; k++) begin
         lane_col[k] = col_q + 2'(k);
         lane_in[k]  = work_q[~lane_col[k]];
      end
   end

   always_comb begin
      work_d = work_q;
      for (int k = 0; k < COLS_PER_CYCLE; k++)
         work_d[~lane_col[k]] = lane_out[k];
   end

   for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_lane
      mix_columns_col u_col (
         .col_i (lane_in[k]),
`ifdef MIX_COLUMNS_INV_EN
         .inv_i (inv_q),
`endif
         .col_o (lane_out[k])
      );
   end

   // 3-bit sum so that col+COLS_PER_CYCLE == 4 is detected without wrap.
   assign last      = ({1'b0, col_q} + 3'(COLS_PER_CYCLE)) == 3'd4;
   assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
   assign out       = out_q;
   assign out_valid = out_valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         col_q       <= 2'd0;
         work_q      <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
`ifdef MIX_COLUMNS_INV_EN
         inv_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  work_q  <= in;
                  col_q   <= 2'd0;
`ifdef MIX_COLUMNS_INV_EN
                  inv_q   <= inv;
`endif
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               work_q <= work_d;
               if (last) begin
                  out_q       <= work_d;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  col_q <= col_q + 2'(COLS_PER_CYCLE);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  if (in_valid) begin
                     // Old result leaves and the next state enters on one edge.
                     work_q  <= in;
                     col_q   <= 2'd0;
`ifdef MIX_COLUMNS_INV_EN
                     inv_q   <= inv;
`endif
                     state_q <= BUSY;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mix_columns_iter.sv
// Testbench for mix_columns_iter: directed FIPS-197 / column-identity vectors
// plus random states compared against a GF(2^8) matrix reference model.
module tb_mix_columns_iter;
   localparam int N = 1;
   localparam int L = 4 / N;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [127:0] in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] out_data;
   logic         out_valid;
   logic         out_ready = 1'b0;
`ifdef MIX_COLUMNS_INV_EN
   logic         inv = 1'b0;
`endif

   int vectors = 0;
   int errs    = 0;

   localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;

   mix_columns_iter #(.COLS_PER_CYCLE(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in        (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
`ifdef MIX_COLUMNS_INV_EN
      .inv       (inv),
`endif
      .out       (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] rnd128;
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Carry-less product, then reduction modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] p;
      p = '0;
      for (int i = 0; i < 8; i++)
         if (b[i]) p = p ^ (15'(a) << i);
      for (int i = 14; i >= 8; i--)
         if (p[i]) p = p ^ (15'h11b << (i - 8));
      return p[7:0];
   endfunction

   // Circulant matrix: row r, input byte j uses base[(j-r) mod 4].
   function automatic logic [127:0] mix(input logic [127:0] s, input bit inv_m);
      logic [7:0]   base [4];
      logic [7:0]   acc;
      logic [127:0] res;
      if (inv_m) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      else       base = '{8'h02, 8'h03, 8'h01, 8'h01};
      res = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            acc = '0;
            for (int j = 0; j < 4; j++)
               acc = acc ^ gmul(base[(j - r + 4) % 4], s[127 - 8*(4*c + j) -: 8]);
            res[127 - 8*(4*c + r) -: 8] = acc;
         end
      return res;
   endfunction

   // Drive one state from IDLE with out_ready=1; return the result and the
   // number of edges after the accept edge until out_valid was seen.
   task automatic do_txn(input logic [127:0] d, output logic [127:0] got, output int lat);
      in_data   = d;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick;
      in_valid = 1'b0;
      in_data  = rnd128();
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick;
         lat++;
      end
      got = out_data;
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b1; in_data = rnd128(); out_ready = 1'b0;
      repeat (3) tick;
      vectors++;
      if (out_data !== 128'h0) begin
         errs++; $display("FAIL reset_out got=%h want=0", out_data);
      end
      vectors++;
      if (out_valid !== 1'b0) begin
         errs++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
      end
      rst = 1'b0; in_valid = 1'b0;
      tick;
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errs++; $display("FAIL reset_no_accept in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_fips;
      logic [127:0] got;
      int lat;
      do_txn(FIPS_IN, got, lat);
      vectors++;
      if (lat !== L) begin
         errs++; $display("FAIL fips_latency got=%0d want=%0d", lat, L);
      end
      vectors++;
      if (got !== FIPS_OUT) begin
         errs++; $display("FAIL fips_out got=%h want=%h", got, FIPS_OUT);
      end
      tick;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errs++; $display("FAIL fips_pulse out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_identities;
      logic [127:0] vin  [3];
      logic [127:0] vout [3];
      logic [127:0] got;
      int lat;
      vin[0]  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
      vout[0] = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
      vin[1]  = 128'h0;
      vout[1] = 128'h0;
      vin[2]  = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
      vout[2] = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;
      for (int i = 0; i < 3; i++) begin
         do_txn(vin[i], got, lat);
         vectors++;
         if (got !== vout[i] || lat !== L) begin
            errs++; $display("FAIL identity%0d got=%h lat=%0d want=%h lat=%0d", i, got, lat, vout[i], L);
         end
         tick;
      end
   endtask

   task automatic test_random;
      logic [127:0] d, got, exp;
      int lat;
      for (int i = 0; i < 24; i++) begin
         d   = rnd128();
         exp = mix(d, 1'b0);
         do_txn(d, got, lat);
         vectors++;
         if (got !== exp || lat !== L) begin
            errs++; $display("FAIL random%0d in=%h got=%h lat=%0d want=%h lat=%0d", i, d, got, lat, exp, L);
         end
         tick;
      end
   endtask

   task automatic test_backpressure;
      logic [127:0] d, exp;
      int lat;
      d   = rnd128();
      exp = mix(d, 1'b0);
      in_data = d; in_valid = 1'b1; out_ready = 1'b0;
      tick;
      // keep in_valid high with new data: must be ignored while busy / held
      in_data = rnd128();
      vectors++;
      if (in_ready !== 1'b0) begin
         errs++; $display("FAIL bp_busy_ready got=%b want=0", in_ready);
      end
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick;
         lat++;
      end
      vectors++;
      if (out_data !== exp || lat !== L) begin
         errs++; $display("FAIL bp_result got=%h lat=%0d want=%h lat=%0d", out_data, lat, exp, L);
      end
      for (int i = 0; i < 10; i++) begin
         tick;
         vectors++;
         if (out_data !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errs++; $display("FAIL bp_hold%0d out=%h ov=%b ir=%b want %h/1/0", i, out_data, out_valid, in_ready, exp);
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== exp) begin
         errs++; $display("FAIL bp_release ov=%b ir=%b out=%h want 0/1/%h", out_valid, in_ready, out_data, exp);
      end
   endtask

   task automatic test_back_to_back;
      logic [127:0] d2, exp2;
      int lat;
      d2   = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
      exp2 = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;
      in_data = FIPS_IN; in_valid = 1'b1; out_ready = 1'b0;
      tick;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick;
         lat++;
      end
      vectors++;
      if (out_data !== FIPS_OUT || out_valid !== 1'b1) begin
         errs++; $display("FAIL b2b_first got=%h ov=%b want=%h/1", out_data, out_valid, FIPS_OUT);
      end
      in_data = d2; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         errs++; $display("FAIL b2b_ready got=%b want=1", in_ready);
      end
      tick;
      in_valid = 1'b0; in_data = rnd128();
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         errs++; $display("FAIL b2b_accept ov=%b ir=%b want 0/0", out_valid, in_ready);
      end
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick;
         lat++;
      end
      vectors++;
      if (out_data !== exp2 || lat !== L) begin
         errs++; $display("FAIL b2b_second got=%h lat=%0d want=%h lat=%0d", out_data, lat, exp2, L);
      end
      tick;
   endtask

   task automatic test_reset_mid;
      in_data = rnd128(); in_valid = 1'b1; out_ready = 1'b1;
      tick;
      in_valid = 1'b0;
      if (L > 1) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      vectors++;
      if (out_data !== 128'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errs++; $display("FAIL rstmid_state out=%h ov=%b ir=%b want 0/0/1", out_data, out_valid, in_ready);
      end
      for (int i = 0; i < 8; i++) begin
         tick;
         vectors++;
         if (out_valid !== 1'b0) begin
            errs++; $display("FAIL rstmid_spurious%0d ov=%b want=0", i, out_valid);
         end
      end
   endtask

`ifdef MIX_COLUMNS_INV_EN
   task automatic test_inv;
      logic [127:0] got, d;
      int lat;
      inv = 1'b1;
      do_txn(FIPS_OUT, got, lat);
      inv = 1'b0;   // latched at accept, so changing it now must not matter
      vectors++;
      if (got !== FIPS_IN || lat !== L) begin
         errs++; $display("FAIL inv_fips got=%h lat=%0d want=%h lat=%0d", got, lat, FIPS_IN, L);
      end
      tick;
      do_txn(FIPS_OUT, got, lat);
      vectors++;
      if (got !== mix(FIPS_OUT, 1'b0)) begin
         errs++; $display("FAIL inv0_fwd got=%h want=%h", got, mix(FIPS_OUT, 1'b0));
      end
      tick;
      for (int i = 0; i < 8; i++) begin
         d = rnd128();
         inv = 1'b1;
         do_txn(d, got, lat);
         vectors++;
         if (got !== mix(d, 1'b1)) begin
            errs++; $display("FAIL inv_random%0d in=%h got=%h want=%h", i, d, got, mix(d, 1'b1));
         end
         tick;
      end
      inv = 1'b0;
   endtask
`endif

   initial begin
      test_reset;
      test_fips;
      test_identities;
      test_random;
      test_backpressure;
      test_back_to_back;
      test_reset_mid;
`ifdef MIX_COLUMNS_INV_EN
      test_inv;
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
